pc_unit: RTL
============

Name: pc_unit

Overview:
- 16-bit program counter and the consumer of the branch unit's control outputs (`branch`, `lower_byte`, `normal`, `pc_increment`).
- Performs sequential increment, absolute loads and 8-bit signed relative branches.
- Absolute loads cover the reset-vector jump and JMP-style targets.
- A relative branch that crosses a page costs one extra fix-up cycle, flagged to the sequencer via `stall`.

Parameters:
- RESET_PC, 16'hFFFC, PC value loaded on reset (reset-vector fetch address).
- PAGE_FIX, 1, 1 = page-crossing relative branch takes the extra FIXUP cycle; 0 = full 16-bit add in one cycle, `stall` never asserted.

Ports:
- clk_2  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset.
- rdy  input  1  1 = advance; 0 = hold every register and output.
- branch  input  1  load request from the branch unit.
- lower_byte  input  1  latch `data_in` as the target low byte.
- normal  input  1  1 = normal operation; 0 = reset sequence in progress (relative mode disabled).
- rel_mode  input  1  1 = `branch` is relative (offset in `data_in`); 0 = absolute.
- pc_increment  input  1  advance PC by one.
- data_in  input  8  data bus: low target byte, high target byte, or signed offset.
- pc  output  16  current program counter.
- stall  output  1  high during the FIXUP cycle.
- page_cross  output  1  one-cycle pulse, registered with the first cycle of a page-crossing relative branch.

Behaviour:
- Reset (`rst`=0 at a clock edge), from any state including mid-FIXUP:
  - pc <= RESET_PC, lo_latch <= 0, state <= RUN, stall <= 0, page_cross <= 0.
  - Other inputs are ignored that cycle.
- `rdy`=0 with `rst`=1: all state frozen (pc, lo_latch, state, stall, page_cross).
- States: RUN, FIXUP. `stall` = (state==FIXUP).
- `lower_byte`=1 in RUN: lo_latch <= data_in. This happens independently of the PC actions below.
- Priority in RUN: `branch` > `pc_increment`. With neither asserted, pc holds.
- Absolute load (`branch`=1 and (`rel_mode`=0 or `normal`=0)):
  - pc <= {data_in, lo_latch}.
  - If `lower_byte` is also 1 that cycle, the target uses the OLD lo_latch; lo_latch still updates.
- Relative branch (`branch`=1, `rel_mode`=1, `normal`=1):
  - off = sign-extended data_in; sum9 = {1'b0, pc[7:0]} + {1'b0, data_in}.
  - crossed = (data_in[7]=0 and sum9[8]=1) or (data_in[7]=1 and sum9[8]=0).
  - Not crossed: pc <= {pc[15:8], sum9[7:0]}, stays RUN, 1 cycle.
  - Crossed, PAGE_FIX=1: pc <= {pc[15:8], sum9[7:0]}; page_cross <= 1; latch direction (up if data_in[7]=0, else down); state <= FIXUP.
  - Crossed, PAGE_FIX=0: pc <= pc + off (mod 2^16), 1 cycle; page_cross still pulses.
- FIXUP (one cycle):
  - pc[15:8] <= pc[15:8] + 1 (up) or − 1 (down), mod 256; pc[7:0] unchanged.
  - page_cross <= 0; state <= RUN.
  - `branch`, `pc_increment` and `lower_byte` are ignored; the sequencer must hold them until `stall` falls.
- page_cross is registered high exactly one cycle, otherwise 0.
- Increment: pc <= pc + 1, 16'hFFFF wraps to 16'h0000.
- A relative branch with offset 0 is legal: pc unchanged, no cross.
- Latency: every PC update is visible on `pc` the cycle after the request edge. Page-crossing branches complete 2 cycles after the request.

Test Plan:
- Reset then vector: rst=0 one edge → pc=FFFC. Then lower_byte=1, data_in=34 → lo_latch=34. Then branch=1, normal=0, rel_mode=1, data_in=12 → pc=1234 (relative ignored).
- Increment wrap: pc=FFFF, pc_increment=1 → pc=0000. Also assert branch and pc_increment together → absolute load wins.
- Relative, no cross: pc=1210, data_in=05 → pc=1215 next edge, stall=0, page_cross=0. Also data_in=F0 → pc=1200.
- Cross forward: pc=12F0, data_in=20 → pc=1210 with page_cross=1, stall=1. Next edge → pc=1310, stall=0. A pc_increment held during FIXUP is ignored.
- Cross backward: pc=1205, data_in=F0 → pc=12F5, then 11F5. Repeat with PAGE_FIX=0 → pc=11F5 in one cycle, stall never 1, page_cross pulses.
- rdy/reset mid-op:
  - rdy=0 in FIXUP holds pc=1210 and stall=1 for 3 cycles, then completes to 1310.
  - rst=0 during FIXUP → pc=FFFC, stall=0 next edge.
  - lower_byte and branch same cycle (lo_latch=34, data_in=56) → pc={56,34}, lo_latch=56.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: 16-bit program counter driven by the branch unit's control outputs.
// It supports sequential increment, absolute loads ({data_in, lo_latch}) and
// 8-bit signed relative branches. When PAGE_FIX is 1, a relative branch that
// crosses a page spends one extra FIXUP cycle correcting the high byte, and
// asserts stall during that cycle.
module pc_unit #(
    parameter logic [15:0] RESET_PC = 16'hFFFC,
    parameter bit          PAGE_FIX = 1'b1
) (
    input  logic        clk_2,
    input  logic        rst,
    input  logic        rdy,
    input  logic        branch,
    input  logic        lower_byte,
    input  logic        normal,
    input  logic        rel_mode,
    input  logic        pc_increment,
    input  logic [7:0]  data_in,
    output logic [15:0] pc,
    output logic        stall,
    output logic        page_cross
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FIXUP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  lo_q, lo_d;
    logic        dir_up_q, dir_up_d;
    logic        page_cross_q, page_cross_d;

    // Relative-branch arithmetic, computed only on the low byte.
    logic [8:0]  sum9_s;
    logic        crossed_s;
    logic [15:0] full_sum_s;

    // Low-byte add plus the carry/sign test that decides whether the page changed.
    always_comb begin
        sum9_s     = {1'b0, pc_q[7:0]} + {1'b0, data_in};
        crossed_s  = (data_in[7] == 1'b0) ? sum9_s[8] : ~sum9_s[8];
        full_sum_s = pc_q + {{8{data_in[7]}}, data_in};
    end

    // State register: synchronous active-low reset; rdy low freezes everything.
    always_ff @(posedge clk_2) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            lo_q         <= 8'h00;
            dir_up_q     <= 1'b0;
            page_cross_q <= 1'b0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            lo_q         <= lo_d;
            dir_up_q     <= dir_up_d;
            page_cross_q <= page_cross_d;
        end else begin
            state_q      <= state_q;
            pc_q         <= pc_q;
            lo_q         <= lo_q;
            dir_up_q     <= dir_up_q;
            page_cross_q <= page_cross_q;
        end
    end

    // Next-state and datapath decisions for RUN and FIXUP.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        lo_d         = lo_q;
        dir_up_d     = dir_up_q;
        page_cross_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                // The low-byte latch updates independently of the PC action;
                // an absolute load in the same cycle still sees the old value.
                if (lower_byte) begin
                    lo_d = data_in;
                end else begin
                    lo_d = lo_q;
                end
                if (branch) begin
                    if (rel_mode && normal) begin
                        if (!crossed_s) begin
                            pc_d = {pc_q[15:8], sum9_s[7:0]};
                        end else if (PAGE_FIX) begin
                            pc_d         = {pc_q[15:8], sum9_s[7:0]};
                            page_cross_d = 1'b1;
                            dir_up_d     = ~data_in[7];
                            state_d      = ST_FIXUP;
                        end else begin
                            pc_d         = full_sum_s;
                            page_cross_d = 1'b1;
                        end
                    end else begin
                        pc_d = {data_in, lo_q};
                    end
                end else if (pc_increment) begin
                    pc_d = pc_q + 16'd1;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_FIXUP: begin
                // Correct the high byte; all sequencer requests are ignored here.
                if (dir_up_q) begin
                    pc_d = {pc_q[15:8] + 8'd1, pc_q[7:0]};
                end else begin
                    pc_d = {pc_q[15:8] - 8'd1, pc_q[7:0]};
                end
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output decode: every output comes straight from a register.
    always_comb begin
        pc         = pc_q;
        page_cross = page_cross_q;
        stall      = (state_q == ST_FIXUP);
    end

endmodule
